cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Arbitrates the single physical-memory line port between the instruction cache (read-only) and the data cache (read/write) of the pipelined RV32I core.
- Latches the winning request, drives one line-sized memory transaction, and returns a one-cycle response to the winner.
- Sits between the two caches and the cacheline adaptor.
- Alternating priority on contention guarantees neither cache starves.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- ADDR_WIDTH, 32, byte address width.
- OFFSET_BITS, 5, low address bits cleared for line alignment (log2 of LINE_WIDTH/8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  ADDR_WIDTH  I-cache request address.
- i_rdata  out  LINE_WIDTH  line returned to I-cache; valid while i_resp=1.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache line write-back request; held until d_resp.
- d_address  in  ADDR_WIDTH  D-cache request address.
- d_wdata  in  LINE_WIDTH  write-back line.
- d_rdata  out  LINE_WIDTH  line returned to D-cache; valid while d_resp=1.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_WIDTH  line-aligned address: latched address with the low OFFSET_BITS bits forced to 0.
- pmem_wdata  out  LINE_WIDTH  latched write line.
- pmem_rdata  in  LINE_WIDTH  memory read line; valid with pmem_resp.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, DONE. Reset state is IDLE.
- Reset values: all outputs 0, last_grant=D (so I wins the first tie), all latches 0.
- IDLE:
  - Only i_read pending -> SERVE_I.
  - Only d_read or d_write pending -> SERVE_D.
  - Both pending -> grant the side opposite last_grant.
  - On every grant edge, latch address, direction (write=d_write) and wdata, and update last_grant.
- d_read and d_write both asserted is illegal; treat it as a write.
- SERVE_x:
  - Drive pmem_read = !latched_write, pmem_write = latched_write. Address and wdata come from the latches only, so input changes are ignored.
  - Hold the strobe until pmem_resp=1.
  - On pmem_resp, register pmem_rdata into the winner's rdata register, then -> DONE.
- DONE:
  - Strobes are 0.
  - The winner's resp is 1 for exactly this cycle, with its rdata valid. The loser's resp is 0.
  - Next state is IDLE, unconditionally.
  - Requesters drop their request in response to resp, so IDLE never re-samples a completed request.
- Latency: request is first seen in IDLE at cycle 0, the strobe is asserted at cycle 1, pmem_resp arrives at cycle k, and resp is asserted at cycle k+1. The minimum gap between grants is 2 idle-ish cycles (DONE, IDLE).
- rdata registers hold their value after DONE until the next completion for the same side.
- A request arriving while the other side is being served waits in IDLE ordering. No preemption and no request queue beyond the held request line.
- pmem_resp in IDLE or DONE is ignored: no state change and no resp.
- rst asserted in any state forces IDLE and reset values on the next edge. An in-flight memory transaction is abandoned; the strobes drop the next cycle.

Test Plan:
- Lone I read: i_read=1, i_address=0x0000_0044, memory responds 3 cycles after the strobe with line L1.
  - Required: pmem_read=1 with pmem_address=0x0000_0040 from cycle 1.
  - Required: i_resp=1 for one cycle with i_rdata=L1.
  - Required: d_resp stays 0 throughout.
- Lone D write-back: d_write=1, d_address=0x0000_1F20, d_wdata=W.
  - Required: pmem_write=1, pmem_address=0x0000_1F20, pmem_wdata=W.
  - Required: d_resp pulses once, pmem_read stays 0.
- Simultaneous after reset: i_read and d_read assert in the same cycle.
  - Required: I is served first. After i_resp and a return to IDLE, D is served next.
  - Next tie: D wins, because last_grant=I.
- Input instability: change d_address and d_wdata mid-SERVE_D.
  - Required: pmem_address and pmem_wdata keep the latched values until pmem_resp.
- Reset mid-transaction: assert rst while in SERVE_I with pmem_read=1.
  - Required: next cycle all outputs are 0 and the state is IDLE.
  - Required: a stale pmem_resp arriving afterward yields no i_resp.
- Illegal D request: d_read=d_write=1.
  - Required: a write transaction is performed (pmem_write=1, pmem_read=0).

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbiter that shares the single physical-memory line port between the I-cache and D-cache.
// On contention the two sides alternate, so neither cache can starve.
module cache_mem_arbiter #(
  parameter int LINE_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

  state_t                state;
  logic                  last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  d_req;
  logic                  grant_d;

  // D wins when it is alone, or on a tie when I had the previous grant
  assign d_req   = d_read | d_write;
  assign grant_d = d_req & (~i_read | ~last_grant_d);

  assign pmem_address = addr_q & LINE_MASK;
  assign pmem_wdata   = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          if (i_read | d_req) begin
            wdata_q      <= d_wdata;
            last_grant_d <= grant_d;
            if (grant_d) begin
              state      <= SERVE_D;
              addr_q     <= d_address;
              // d_read together with d_write is resolved as a write
              pmem_read  <= ~d_write;
              pmem_write <= d_write;
            end else begin
              state      <= SERVE_I;
              addr_q     <= i_address;
              pmem_read  <= 1'b1;
              pmem_write <= 1'b0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            state      <= DONE;
            if (state == SERVE_I) begin
              i_rdata <= pmem_rdata;
              i_resp  <= 1'b1;
            end else begin
              d_rdata <= pmem_rdata;
              d_resp  <= 1'b1;
            end
          end
        end
        default: begin
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: a transaction-level reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_cache_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;

  cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .OFFSET_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: busy flag, who owns the port, and who should win the next tie.
  bit            busy, completing, owner_d, prefer_i;
  bit            m_rd, m_wr, m_iresp, m_dresp;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata, m_irdata, m_drdata;

  always @(posedge clk) begin
    if (rst) begin
      busy = 0; completing = 0; owner_d = 0; prefer_i = 1;
      m_rd = 0; m_wr = 0; m_iresp = 0; m_dresp = 0;
      m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
    end else begin
      m_iresp = 0; m_dresp = 0;
      if (completing) begin
        completing = 0;
      end else if (busy) begin
        if (pmem_resp) begin
          busy = 0; completing = 1; m_rd = 0; m_wr = 0;
          if (owner_d) begin m_drdata = pmem_rdata; m_dresp = 1; end
          else begin m_irdata = pmem_rdata; m_iresp = 1; end
        end
      end else if (i_read || d_read || d_write) begin
        owner_d  = (d_read || d_write) && (!i_read || !prefer_i);
        prefer_i = owner_d;
        m_addr   = (owner_d ? d_address : i_address) & 32'hFFFF_FFE0;
        m_wdata  = d_wdata;
        m_wr     = owner_d && d_write;
        m_rd     = !m_wr;
        busy     = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("pmem_read",    pmem_read,    m_rd);
      chk("pmem_write",   pmem_write,   m_wr);
      chk("pmem_address", pmem_address, m_addr);
      chk("pmem_wdata",   pmem_wdata,   m_wdata);
      chk("i_resp",       i_resp,       m_iresp);
      chk("d_resp",       d_resp,       m_dresp);
      chk("i_rdata",      i_rdata,      m_irdata);
      chk("d_rdata",      d_rdata,      m_drdata);
    end
  end

  task automatic wait_strobe();
    int n = 0;
    while (!(pmem_read || pmem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(pmem_read || pmem_write)) begin
      vectors++;
      fails++;
      $display("FAIL strobe_timeout: got no strobe expected strobe within 20 cycles");
    end
  endtask

  // Memory answers 'delay' cycles after the strobe was first seen
  task automatic respond(input int delay, input logic [LW-1:0] data);
    repeat (delay - 1) @(negedge clk);
    pmem_rdata = data;
    pmem_resp  = 1'b1;
    @(negedge clk);
    pmem_resp  = 1'b0;
  endtask

  logic [LW-1:0] l1, l2, l3, l4, w1, w2, w3;

  initial begin
    l1 = {8{32'hA5A5_0001}};
    l2 = {8{32'h5A5A_0002}};
    l3 = {8{32'h1234_0003}};
    l4 = {8{32'hDEAD_0004}};
    w1 = {8{32'hCAFE_F00D}};
    w2 = {8{32'h0BAD_BEEF}};
    w3 = {8{32'h7777_1111}};
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    repeat (2) @(negedge clk);
    started = 1'b1;
    chk("reset_pmem_read", pmem_read, 0);
    chk("reset_pmem_address", pmem_address, 0);
    chk("reset_i_resp", i_resp, 0);
    rst = 1'b0;
    @(negedge clk);

    // Lone I read
    i_read = 1; i_address = 32'h0000_0044;
    @(negedge clk);
    chk("lone_i_strobe_c1", pmem_read, 1);
    chk("lone_i_addr_c1", pmem_address, 32'h0000_0040);
    wait_strobe();
    respond(3, l1);
    chk("lone_i_resp", i_resp, 1);
    chk("lone_i_rdata", i_rdata, l1);
    chk("lone_i_no_dresp", d_resp, 0);
    i_read = 0;
    repeat (2) @(negedge clk);
    chk("lone_i_resp_one_cycle", i_resp, 0);

    // Tie with I granted last: D wins, then I
    i_read = 1; i_address = 32'h0000_0100;
    d_read = 1; d_address = 32'h0000_2008;
    wait_strobe();
    chk("tie_d_first_addr", pmem_address, 32'h0000_2000);
    respond(2, l2);
    chk("tie_d_first_resp", d_resp, 1);
    chk("tie_d_first_rdata", d_rdata, l2);
    chk("tie_d_first_no_iresp", i_resp, 0);
    d_read = 0;
    @(negedge clk);
    wait_strobe();
    chk("tie_i_second_addr", pmem_address, 32'h0000_0100);
    respond(1, l3);
    chk("tie_i_second_resp", i_resp, 1);
    chk("d_rdata_held", d_rdata, l2);
    i_read = 0;
    repeat (2) @(negedge clk);

    // Lone D write-back with unstable inputs mid-transaction
    d_write = 1; d_address = 32'h0000_1F20; d_wdata = w1;
    wait_strobe();
    chk("wb_write", pmem_write, 1);
    chk("wb_read_low", pmem_read, 0);
    d_address = 32'h0000_3344; d_wdata = w2;
    @(negedge clk);
    chk("wb_addr_latched", pmem_address, 32'h0000_1F20);
    chk("wb_wdata_latched", pmem_wdata, w1);
    respond(2, l4);
    chk("wb_resp", d_resp, 1);
    d_write = 0;
    repeat (2) @(negedge clk);

    // Tie straight after reset: I first, then D
    rst = 1;
    @(negedge clk);
    rst = 0;
    i_read = 1; i_address = 32'h0000_0A00;
    d_read = 1; d_address = 32'h0000_0B00;
    wait_strobe();
    chk("rst_tie_i_first", pmem_address, 32'h0000_0A00);
    respond(2, l1);
    chk("rst_tie_iresp", i_resp, 1);
    i_read = 0;
    @(negedge clk);
    wait_strobe();
    chk("rst_tie_d_second", pmem_address, 32'h0000_0B00);
    respond(2, l3);
    chk("rst_tie_dresp", d_resp, 1);
    chk("rst_tie_drdata", d_rdata, l3);
    d_read = 0;
    repeat (2) @(negedge clk);

    // Illegal d_read with d_write acts as a write
    d_read = 1; d_write = 1; d_address = 32'h0000_4040; d_wdata = w3;
    wait_strobe();
    chk("illegal_write", pmem_write, 1);
    chk("illegal_no_read", pmem_read, 0);
    chk("illegal_wdata", pmem_wdata, w3);
    respond(1, l2);
    chk("illegal_resp", d_resp, 1);
    d_read = 0; d_write = 0;
    repeat (2) @(negedge clk);

    // Reset mid-transaction, then a stale memory response
    i_read = 1; i_address = 32'h0000_0C60;
    wait_strobe();
    chk("midrst_strobe", pmem_read, 1);
    rst = 1;
    @(negedge clk);
    chk("midrst_read", pmem_read, 0);
    chk("midrst_addr", pmem_address, 0);
    chk("midrst_iresp", i_resp, 0);
    rst = 0; i_read = 0;
    pmem_rdata = l4; pmem_resp = 1;
    @(negedge clk);
    pmem_resp = 0;
    chk("stale_iresp_a", i_resp, 0);
    @(negedge clk);
    chk("stale_iresp_b", i_resp, 0);
    chk("stale_irdata", i_rdata, 0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
